// File: rtl/riscv_multicycle_core_if.sv
// Shared instruction/data memory port with a valid/ready handshake.
// The core is the master; the memory (or a bench model) is the slave.
interface riscv_multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: one FSM walks FETCH/DECODE/EXEC/MEM/WB over a single
// shared memory port, halting sticky on any illegal or unsupported event.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  riscv_multicycle_core_if.master mem,
  output logic [31:0]             pc_out,
  output logic [31:0]             instruction_out,
  output logic                    trap,
  output logic [31:0]             retire_count
);
  localparam int RW = (NUM_REGS == 16) ? 4 : 5;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_OPI = 7'b0010011, OP_OP = 7'b0110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q, npc_q, ret_q;
  logic        trap_q;
  logic [31:0] rf_q [NUM_REGS];

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_br    = (opc == OP_BR);
  assign is_ld    = (opc == OP_LD);
  assign is_st    = (opc == OP_ST);
  assign is_opi   = (opc == OP_OPI);
  assign is_op    = (opc == OP_OP);

  logic [31:0] imm_c;
  always_comb begin
    imm_c = {{20{ir_q[31]}}, ir_q[31:20]};
    if (is_lui || is_auipc) imm_c = {ir_q[31:12], 12'b0};
    else if (is_jal)        imm_c = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    else if (is_br)         imm_c = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    else if (is_st)         imm_c = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  end

  logic legal, use_rs1, use_rs2, use_rd;
  always_comb begin
    legal   = 1'b0;
    use_rs1 = is_jalr || is_br || is_ld || is_st || is_opi || is_op;
    use_rs2 = is_br || is_st || is_op;
    use_rd  = !(is_br || is_st);
    unique case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:      legal = (f3 == 3'b000);
      OP_BR:        legal = (f3 != 3'b010) && (f3 != 3'b011);
      OP_LD, OP_ST: legal = (f3 == 3'b010);
      OP_OPI:       legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                            (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OP_OP:        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      default:      legal = 1'b0;
    endcase
  end

  // RV32E: any used register field with bit 4 set names a nonexistent register.
  logic reg_bad;
  assign reg_bad = (NUM_REGS < 32) &&
                   ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));

  logic [31:0] op_a, op_b, alu_res, sra_res, result, tgt;
  logic [2:0]  alu_f3;
  assign op_a    = is_auipc ? pc_q : a_q;
  assign op_b    = is_op ? b_q : imm_q;
  assign alu_f3  = (is_op || is_opi) ? f3 : 3'b000;
  assign sra_res = $signed(op_a) >>> op_b[4:0];
  always_comb begin
    unique case (alu_f3)
      3'b000:  alu_res = (is_op && f7[5]) ? op_a - op_b : op_a + op_b;
      3'b001:  alu_res = op_a << op_b[4:0];
      3'b010:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      3'b011:  alu_res = {31'b0, op_a < op_b};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = f7[5] ? sra_res : op_a >> op_b[4:0];
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end
  assign result = is_lui ? imm_q : (is_jal || is_jalr) ? pc_q + 32'd4 : alu_res;
  assign tgt    = is_jalr ? ((a_q + imm_q) & ~32'd1) : pc_q + imm_q;

  logic taken;
  always_comb begin
    unique case (f3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = ($signed(a_q) < $signed(b_q));
      3'b101:  taken = !($signed(a_q) < $signed(b_q));
      3'b110:  taken = (a_q < b_q);
      default: taken = !(a_q < b_q);
    endcase
  end

  logic trap_c;
  assign trap_c = !legal || reg_bad ||
                  ((is_ld || is_st) && alu_res[1:0] != 2'b00) ||
                  ((is_jal || is_jalr || (is_br && taken)) && tgt[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      npc_q   <= '0;
      ret_q   <= '0;
      trap_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: if (mem.mem_ready) begin
          ir_q    <= mem.mem_rdata;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rf_q[rs1[RW-1:0]];
          b_q     <= rf_q[rs2[RW-1:0]];
          imm_q   <= imm_c;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (trap_c) begin
            trap_q  <= 1'b1;
            state_q <= S_HALT;
          end else if (is_br) begin
            pc_q    <= taken ? tgt : pc_q + 32'd4;
            ret_q   <= ret_q + 32'd1;
            state_q <= S_FETCH;
          end else begin
            alu_q   <= result;
            npc_q   <= (is_jal || is_jalr) ? tgt : pc_q + 32'd4;
            state_q <= (is_ld || is_st) ? S_MEM : S_WB;
          end
        end
        S_MEM: if (mem.mem_ready) begin
          if (is_st) begin
            pc_q    <= npc_q;
            ret_q   <= ret_q + 32'd1;
            state_q <= S_FETCH;
          end else begin
            mdr_q   <= mem.mem_rdata;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (rd != 5'd0) rf_q[rd[RW-1:0]] <= is_ld ? mdr_q : alu_q;
          pc_q    <= npc_q;
          ret_q   <= ret_q + 32'd1;
          state_q <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Gated by reset directly so the bus is quiet for the whole time reset is held low.
  logic in_mem;
  assign in_mem        = reset && (state_q == S_MEM);
  assign mem.mem_req   = reset && (state_q == S_FETCH || state_q == S_MEM);
  assign mem.mem_we    = in_mem && is_st;
  assign mem.mem_addr  = (reset && state_q == S_FETCH) ? pc_q : in_mem ? alu_q : 32'd0;
  assign mem.mem_wdata = (in_mem && is_st) ? b_q : 32'd0;

  assign pc_out          = pc_q;
  assign instruction_out = ir_q;
  assign trap            = trap_q;
  assign retire_count    = ret_q;
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench: a word memory with configurable wait states drives the main core;
// a second RV32E instance is fed a fixed instruction stream.
module tb_riscv_multicycle_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_out, ir_out, ret_cnt, pc16, ir16, ret16;
  logic        trap, trap16;
  int          total = 0, bad = 0;

  riscv_multicycle_core_if bus();
  riscv_multicycle_core_if bus16();

  riscv_multicycle_core #(.RESET_PC(32'h0), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .mem(bus), .pc_out(pc_out), .instruction_out(ir_out),
    .trap(trap), .retire_count(ret_cnt));

  riscv_multicycle_core #(.RESET_PC(32'h0), .NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .mem(bus16), .pc_out(pc16), .instruction_out(ir16),
    .trap(trap16), .retire_count(ret16));

  logic [31:0] e_instr = 32'h0;
  assign bus16.mem_ready = bus16.mem_req;
  assign bus16.mem_rdata = e_instr;

  always #5 clk = ~clk;

  // Memory model: responds on the falling edge, ready after wait_n wait cycles.
  logic [31:0] mem [256];
  int          wait_n = 0, cnt = 0, stab_err = 0, we_cycles = 0, we_done = 0;
  logic [31:0] h_addr, h_wdata, last_waddr, last_wdata;
  logic        h_we;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) cnt = 0;
      bus.mem_ready = 1'b0;
      if (bus.mem_req) begin
        if (cnt == 0) begin
          h_addr = bus.mem_addr; h_we = bus.mem_we; h_wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== h_addr || bus.mem_we !== h_we || bus.mem_wdata !== h_wdata)
          stab_err++;
        if (bus.mem_we) we_cycles++;
        if (cnt >= wait_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[9:2]];
          if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            we_done++; last_waddr = bus.mem_addr; last_wdata = bus.mem_wdata;
          end
        end
        cnt++;
      end else cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    stab_err = 0; we_cycles = 0; we_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
    total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL rst_ir got=%h exp=0", ir_out); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL rst_trap got=%b exp=0", trap); end
    total++; if (ret_cnt !== 32'h0) begin bad++; $display("FAIL rst_ret got=%0d exp=0", ret_cnt); end
  endtask

  task automatic test_addi();
    clear_mem(); wait_n = 0;
    mem[0] = 32'h00500093;                // ADDI x1,x0,5
    do_reset();
    tick(3);
    total++; if (ret_cnt !== 32'd0) begin bad++; $display("FAIL addi_early_ret got=%0d exp=0", ret_cnt); end
    tick(1);
    total++; if (ret_cnt !== 32'd1) begin bad++; $display("FAIL addi_ret got=%0d exp=1", ret_cnt); end
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL addi_pc got=%h exp=4", pc_out); end
    total++; if (dut.rf_q[1] !== 32'd5) begin bad++; $display("FAIL addi_x1 got=%h exp=5", dut.rf_q[1]); end
  endtask

  task automatic test_store_load();
    clear_mem(); wait_n = 3;
    mem[0] = 32'h00500093;                // ADDI x1,x0,5
    mem[1] = 32'h04102023;                // SW x1,64(x0)
    mem[2] = 32'h04002103;                // LW x2,64(x0)
    do_reset();
    tick(27);
    total++; if (ret_cnt !== 32'd2) begin bad++; $display("FAIL sl_early_ret got=%0d exp=2", ret_cnt); end
    tick(1);
    total++; if (ret_cnt !== 32'd3) begin bad++; $display("FAIL sl_ret got=%0d exp=3", ret_cnt); end
    total++; if (pc_out !== 32'hC) begin bad++; $display("FAIL sl_pc got=%h exp=c", pc_out); end
    total++; if (dut.rf_q[2] !== 32'd5) begin bad++; $display("FAIL sl_x2 got=%h exp=5", dut.rf_q[2]); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL sl_stable got=%0d exp=0", stab_err); end
    total++; if (we_done !== 1) begin bad++; $display("FAIL sl_writes got=%0d exp=1", we_done); end
    total++; if (we_cycles !== 4) begin bad++; $display("FAIL sl_we_cycles got=%0d exp=4", we_cycles); end
    total++; if (last_waddr !== 32'h40) begin bad++; $display("FAIL sl_waddr got=%h exp=40", last_waddr); end
    total++; if (last_wdata !== 32'd5) begin bad++; $display("FAIL sl_wdata got=%h exp=5", last_wdata); end
    wait_n = 0;
  endtask

  task automatic test_branch();
    clear_mem(); wait_n = 0;
    mem[0] = 32'hFFF00093;                // ADDI x1,x0,-1
    mem[1] = 32'h00106463;                // BLTU x0,x1,+8 (taken)
    mem[3] = 32'h00104463;                // BLT  x0,x1,+8 (not taken)
    do_reset();
    tick(4);
    tick(2);
    total++; if (ret_cnt !== 32'd1) begin bad++; $display("FAIL bltu_early_ret got=%0d exp=1", ret_cnt); end
    tick(1);
    total++; if (pc_out !== 32'hC) begin bad++; $display("FAIL bltu_pc got=%h exp=c", pc_out); end
    total++; if (ret_cnt !== 32'd2) begin bad++; $display("FAIL bltu_ret got=%0d exp=2", ret_cnt); end
    tick(3);
    total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL blt_pc got=%h exp=10", pc_out); end
    total++; if (ret_cnt !== 32'd3) begin bad++; $display("FAIL blt_ret got=%0d exp=3", ret_cnt); end
    total++; if (dut.rf_q[8] !== 32'd0) begin bad++; $display("FAIL br_nowrite got=%h exp=0", dut.rf_q[8]); end
    total++; if (dut.rf_q[1] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL br_x1 got=%h exp=ffffffff", dut.rf_q[1]); end
  endtask

  task automatic test_jal();
    clear_mem(); wait_n = 0;
    mem[0]  = 32'h0200006F;               // JAL x0,+32
    mem[8]  = 32'h010000EF;               // JAL x1,+16 at 0x20
    mem[12] = 32'h00108067;               // JALR x0,1(x1) at 0x30
    do_reset();
    tick(4);
    total++; if (pc_out !== 32'h20) begin bad++; $display("FAIL jal0_pc got=%h exp=20", pc_out); end
    tick(4);
    total++; if (pc_out !== 32'h30) begin bad++; $display("FAIL jal_pc got=%h exp=30", pc_out); end
    total++; if (dut.rf_q[1] !== 32'h24) begin bad++; $display("FAIL jal_x1 got=%h exp=24", dut.rf_q[1]); end
    tick(4);
    total++; if (pc_out !== 32'h24) begin bad++; $display("FAIL jalr_pc got=%h exp=24", pc_out); end
    total++; if (ret_cnt !== 32'd3) begin bad++; $display("FAIL jalr_ret got=%0d exp=3", ret_cnt); end
    total++; if (dut.rf_q[0] !== 32'd0) begin bad++; $display("FAIL jalr_x0 got=%h exp=0", dut.rf_q[0]); end
  endtask

  task automatic test_trap_misaligned();
    clear_mem(); wait_n = 0;
    mem[0] = 32'h00602103;                // LW x2,6(x0)
    do_reset();
    tick(2);
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL mis_early_trap got=%b exp=0", trap); end
    tick(1);
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL mis_trap got=%b exp=1", trap); end
    tick(10);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", bus.mem_req); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL mis_pc got=%h exp=0", pc_out); end
    total++; if (ret_cnt !== 32'd0) begin bad++; $display("FAIL mis_ret got=%0d exp=0", ret_cnt); end
  endtask

  task automatic test_ecall();
    clear_mem(); wait_n = 0;
    mem[0] = 32'h00500093;                // ADDI x1,x0,5
    mem[1] = 32'h00000073;                // ECALL
    do_reset();
    tick(7);
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL ecall_trap got=%b exp=1", trap); end
    tick(5);
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL ecall_pc got=%h exp=4", pc_out); end
    total++; if (ret_cnt !== 32'd1) begin bad++; $display("FAIL ecall_ret got=%0d exp=1", ret_cnt); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL ecall_req got=%b exp=0", bus.mem_req); end
  endtask

  task automatic test_reset_mid();
    clear_mem(); wait_n = 0;
    mem[0] = 32'h00500093;                // ADDI x1,x0,5
    do_reset();
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL rm_trap_clear got=%b exp=0", trap); end
    tick(4);
    wait_n = 10;
    tick(2);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rm_waiting got=%b exp=1", bus.mem_req); end
    reset = 1'b0;
    tick(1);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", bus.mem_req); end
    tick(1);
    reset = 1'b1; wait_n = 0;
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rm_pc got=%h exp=0", pc_out); end
    total++; if (ret_cnt !== 32'd0) begin bad++; $display("FAIL rm_ret got=%0d exp=0", ret_cnt); end
    total++; if (dut.rf_q[1] !== 32'd0) begin bad++; $display("FAIL rm_x1 got=%h exp=0", dut.rf_q[1]); end
  endtask

  task automatic test_rv32e();
    e_instr = 32'h00100793;               // ADDI x15,x0,1
    do_reset();
    tick(4);
    total++; if (ret16 !== 32'd1) begin bad++; $display("FAIL e_x15_ret got=%0d exp=1", ret16); end
    total++; if (dut16.rf_q[15] !== 32'd1) begin bad++; $display("FAIL e_x15 got=%h exp=1", dut16.rf_q[15]); end
    e_instr = 32'h00100A13;               // ADDI x20,x0,1
    tick(2);
    total++; if (trap16 !== 1'b0) begin bad++; $display("FAIL e_early_trap got=%b exp=0", trap16); end
    tick(1);
    total++; if (trap16 !== 1'b1) begin bad++; $display("FAIL e_x20_trap got=%b exp=1", trap16); end
    total++; if (ret16 !== 32'd1) begin bad++; $display("FAIL e_x20_ret got=%0d exp=1", ret16); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store_load();
    test_branch();
    test_jal();
    test_trap_misaligned();
    test_ecall();
    test_reset_mid();
    test_rv32e();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
